// File: rtl/fp_pkg.sv
// Shared FP32 format constants, operand struct and divider state encoding.
package fp_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned FP_MANT_W = 24;  // hidden one plus 23 fraction bits
    localparam int unsigned FP_QUO_W  = 26;  // quotient bits, MSB has weight 2^0

    localparam logic [7:0]  FP_BIAS    = 8'd127;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StNorm
    } div_state_e;

endpackage

// File: rtl/fp_divide_if.sv
// Start/done handshake, operands, result and flags of the FP divider.
interface fp_divide_if;
    import fp_pkg::*;

    logic              div_start;
    logic [FP_W-1:0]   op1;
    logic [FP_W-1:0]   op2;
    logic [FP_W-1:0]   div_result;
    logic              div_done;
    logic              div_busy;
    logic              div_overflow;
    logic              div_underflow;
    logic              div_by_zero;

    modport master (
        output div_start, op1, op2,
        input  div_result, div_done, div_busy, div_overflow, div_underflow, div_by_zero
    );

    modport slave (
        input  div_start, op1, op2,
        output div_result, div_done, div_busy, div_overflow, div_underflow, div_by_zero
    );

endinterface

// File: rtl/fp_div_mant.sv
// Radix-2 restoring mantissa divider producing one quotient bit per clock, 26 steps per load.
module fp_div_mant
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 i_load,
    input  logic [FP_MANT_W-1:0] i_m1,
    input  logic [FP_MANT_W-1:0] i_m2,
    output logic [FP_QUO_W-1:0]  o_q,
    output logic                 o_rem_nz,
    output logic                 o_mant_done
);

    logic [FP_QUO_W-1:0]  r_rem;
    logic [FP_QUO_W-1:0]  r_q;
    logic [FP_MANT_W-1:0] r_m2;
    logic [4:0]           r_cnt;
    logic                 r_active;

    logic                 w_ge;
    logic [FP_QUO_W-1:0]  w_diff;
    logic                 w_last;

    // One restoring step: conditional subtract, then shift the remainder left.
    always_comb begin
        w_ge   = (r_rem >= {2'b00, r_m2});
        w_diff = w_ge ? (r_rem - {2'b00, r_m2}) : r_rem;
        w_last = r_active && (r_cnt == 5'd25);
    end

    // Remainder, quotient and step counter; quotient fills MSB first via left shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rem    <= '0;
            r_q      <= '0;
            r_m2     <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_rem    <= {2'b00, i_m1};
            r_q      <= '0;
            r_m2     <= i_m2;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_rem <= w_diff << 1;
            r_q   <= {r_q[FP_QUO_W-2:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_q         = r_q;
    assign o_rem_nz    = (r_rem != '0);
    // High during the cycle whose closing edge performs the final step.
    assign o_mant_done = w_last;

endmodule

// File: rtl/fp_divide.sv
// Sequential IEEE-754 single-precision divider (start/done handshake).
// Build option: define FP_DIV_RNE_EN for round-to-nearest-even; otherwise truncate.
module fp_divide
    import fp_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    fp_divide_if.slave bus
);

`ifdef FP_DIV_RNE_EN
    localparam bit RneEn = 1'b1;
`else
    localparam bit RneEn = 1'b0;
`endif

    div_state_e        r_state, w_state_next;

    logic              r_sign;
    logic signed [9:0] r_exp;
    logic              r_special;
    logic [31:0]       r_special_res;
    logic              r_special_dbz;

    logic [31:0]       r_result;
    logic              r_done;
    logic              r_ovf;
    logic              r_unf;
    logic              r_dbz;

    fp32_t             w_a, w_b;
    logic              w_a_zero, w_b_zero, w_any_max;
    logic              w_accept;
    logic              w_sign;
    logic signed [9:0] w_exp;
    logic              w_special;
    logic [31:0]       w_special_res;
    logic              w_special_dbz;

    logic [FP_QUO_W-1:0] w_q;
    logic                w_rem_nz;
    logic                w_mant_done;

    logic signed [9:0] w_e_adj, w_e_fin;
    logic [22:0]       w_mant;
    logic              w_guard, w_sticky, w_inc;
    logic [23:0]       w_mant_rnd;
    logic [31:0]       w_norm_res;
    logic              w_norm_ovf, w_norm_unf;

    assign w_a       = bus.op1;
    assign w_b       = bus.op2;
    // Exponent 0 covers both true zero and denormals, which are flushed to zero.
    assign w_a_zero  = (w_a.exp == 8'h00);
    assign w_b_zero  = (w_b.exp == 8'h00);
    assign w_any_max = (w_a.exp == FP_EXP_MAX) || (w_b.exp == FP_EXP_MAX);
    assign w_accept  = (r_state == StIdle) && bus.div_start;
    assign w_sign    = w_a.sign ^ w_b.sign;
    assign w_exp     = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp})
                     + $signed({2'b00, FP_BIAS});

    // Special-operand decode; priority order matters (inf/NaN, then 0/0, then x/0, then 0/x).
    always_comb begin
        w_special     = 1'b1;
        w_special_res = FP_QNAN;
        w_special_dbz = 1'b0;
        if (w_any_max) begin
            w_special_res = FP_QNAN;
        end else if (w_a_zero && w_b_zero) begin
            w_special_res = FP_QNAN;
        end else if (w_b_zero) begin
            w_special_res = {w_sign, FP_EXP_MAX, 23'h0};
            w_special_dbz = 1'b1;
        end else if (w_a_zero) begin
            w_special_res = {w_sign, 31'h0};
        end else begin
            w_special = 1'b0;
        end
    end

    fp_div_mant u_mant (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_load      (w_accept && !w_special),
        .i_m1        ({1'b1, w_a.frac}),
        .i_m2        ({1'b1, w_b.frac}),
        .o_q         (w_q),
        .o_rem_nz    (w_rem_nz),
        .o_mant_done (w_mant_done)
    );

    // Next-state logic; special cases go straight to NORM so done follows one cycle later.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (bus.div_start) w_state_next = w_special ? StNorm : StDivide;
            StDivide: if (w_mant_done) w_state_next = StNorm;
            StNorm:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Normalise the quotient, optionally round, and range-check the exponent.
    always_comb begin
        w_e_adj  = r_exp;
        w_mant   = w_q[24:2];
        w_guard  = w_q[1];
        w_sticky = w_q[0] | w_rem_nz;
        if (!w_q[25]) begin
            w_mant   = w_q[23:1];
            w_guard  = w_q[0];
            w_sticky = w_rem_nz;
            w_e_adj  = r_exp - 10'sd1;
        end
        w_inc      = RneEn && w_guard && (w_sticky || w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + {23'h0, w_inc};
        // Carry to 2.0 leaves the fraction at zero and bumps the exponent.
        w_e_fin    = w_mant_rnd[23] ? (w_e_adj + 10'sd1) : w_e_adj;
        w_norm_ovf = 1'b0;
        w_norm_unf = 1'b0;
        if (w_e_fin >= 10'sd255) begin
            w_norm_res = {r_sign, FP_EXP_MAX, 23'h0};
            w_norm_ovf = 1'b1;
        end else if (w_e_fin <= 10'sd0) begin
            w_norm_res = {r_sign, 31'h0};
            w_norm_unf = 1'b1;
        end else begin
            w_norm_res = {r_sign, w_e_fin[7:0], w_mant_rnd[22:0]};
        end
    end

    // Operand-derived context captured on an accepted start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_special     <= 1'b0;
            r_special_res <= '0;
            r_special_dbz <= 1'b0;
        end else if (w_accept) begin
            r_sign        <= w_sign;
            r_exp         <= w_exp;
            r_special     <= w_special;
            r_special_res <= w_special_res;
            r_special_dbz <= w_special_dbz;
        end
    end

    // Output registers: flags clear on accept, result and flags load on completion.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
                r_dbz <= 1'b0;
            end
            if (r_state == StNorm) begin
                r_done <= 1'b1;
                if (r_special) begin
                    r_result <= r_special_res;
                    r_ovf    <= 1'b0;
                    r_unf    <= 1'b0;
                    r_dbz    <= r_special_dbz;
                end else begin
                    r_result <= w_norm_res;
                    r_ovf    <= w_norm_ovf;
                    r_unf    <= w_norm_unf;
                    r_dbz    <= 1'b0;
                end
            end
        end
    end

    assign bus.div_result    = r_result;
    assign bus.div_done      = r_done;
    assign bus.div_busy      = (r_state != StIdle);
    assign bus.div_overflow  = r_ovf;
    assign bus.div_underflow = r_unf;
    assign bus.div_by_zero   = r_dbz;

endmodule

// File: tb/tb_fp_divide.sv
// Directed self-checking bench for fp_divide.
module tb_fp_divide;

    logic clk;
    logic n_rst;
    int   n_vec;
    int   n_miss;

    fp_divide_if bus_if ();

    fp_divide u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        logic [2:0]  flg;  // {overflow, underflow, by_zero}
    } vec_t;

`ifdef FP_DIV_RNE_EN
    localparam logic [31:0] OneThird = 32'h3EAAAAAB;
`else
    localparam logic [31:0] OneThird = 32'h3EAAAAAA;
`endif

    // Issue one operation from the #1-after-edge phase and wait (bounded) for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [2:0] flg, output int lat);
        bus_if.op1       = a;
        bus_if.op2       = b;
        bus_if.div_start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.div_start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus_if.div_done && lat < 40);
        res = bus_if.div_result;
        flg = {bus_if.div_overflow, bus_if.div_underflow, bus_if.div_by_zero};
    endtask

    task automatic test_reset();
        bus_if.div_start = 1'b0;
        bus_if.op1       = 32'h0;
        bus_if.op2       = 32'h0;
        n_rst            = 1'b1;
        #2;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus_if.div_result !== 32'h0) begin
            n_miss++;
            $display("FAIL reset_result: got %h expected %h", bus_if.div_result, 32'h0);
        end
        n_vec++;
        if ({bus_if.div_done, bus_if.div_busy} !== 2'b00) begin
            n_miss++;
            $display("FAIL reset_done_busy: got %b expected 00",
                     {bus_if.div_done, bus_if.div_busy});
        end
        n_vec++;
        if ({bus_if.div_overflow, bus_if.div_underflow, bus_if.div_by_zero} !== 3'b000) begin
            n_miss++;
            $display("FAIL reset_flags: got %b expected 000",
                     {bus_if.div_overflow, bus_if.div_underflow, bus_if.div_by_zero});
        end
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors();
        vec_t        v[16];
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        v[0]  = '{32'h40C00000, 32'h40400000, 32'h40000000, 27, 3'b000};
        v[1]  = '{32'h3FF00000, 32'h3FC00000, 32'h3FA00000, 27, 3'b000};
        v[2]  = '{32'hC0C00000, 32'h40400000, 32'hC0000000, 27, 3'b000};
        v[3]  = '{32'h3F800000, 32'h40400000, OneThird,     27, 3'b000};
        v[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1,  3'b001};
        v[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1,  3'b000};
        v[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 27, 3'b100};
        v[7]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 27, 3'b010};
        v[8]  = '{32'h80000000, 32'h40000000, 32'h80000000, 1,  3'b000};
        v[9]  = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 1,  3'b000};
        v[10] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1,  3'b001};
        v[11] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 27, 3'b000};
        v[12] = '{32'h00800000, 32'h40000000, 32'h00000000, 27, 3'b010};
        v[13] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 27, 3'b100};
        v[14] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 27, 3'b000};
        v[15] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1,  3'b000};
        for (int i = 0; i < 16; i++) begin
            run_op(v[i].a, v[i].b, res, flg, lat);
            n_vec++;
            if (res !== v[i].res) begin
                n_miss++;
                $display("FAIL vec%0d_result: %h/%h got %h expected %h",
                         i, v[i].a, v[i].b, res, v[i].res);
            end
            n_vec++;
            if (lat != v[i].lat) begin
                n_miss++;
                $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
            end
            n_vec++;
            if (flg !== v[i].flg) begin
                n_miss++;
                $display("FAIL vec%0d_flags: got %b expected %b", i, flg, v[i].flg);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_busy_ignore();
        int cnt;
        bus_if.op1       = 32'h40C00000;
        bus_if.op2       = 32'h40400000;
        bus_if.div_start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.div_start = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        n_vec++;
        if (bus_if.div_busy !== 1'b1) begin
            n_miss++;
            $display("FAIL busy_mid_op: got %b expected 1", bus_if.div_busy);
        end
        // Competing request with different operands must be ignored.
        bus_if.op1       = 32'h3F800000;
        bus_if.op2       = 32'h40400000;
        bus_if.div_start = 1'b1;
        @(posedge clk);
        #1;
        cnt++;
        bus_if.div_start = 1'b0;
        while (!bus_if.div_done && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        n_vec++;
        if (cnt != 27) begin
            n_miss++;
            $display("FAIL busy_ignore_latency: got %0d expected 27", cnt);
        end
        n_vec++;
        if (bus_if.div_result !== 32'h40000000) begin
            n_miss++;
            $display("FAIL busy_ignore_result: got %h expected %h",
                     bus_if.div_result, 32'h40000000);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        int          cnt;
        run_op(32'h7F000000, 32'h3E800000, res, flg, lat);
        n_vec++;
        if ({res, flg} !== {32'h7F800000, 3'b100}) begin
            n_miss++;
            $display("FAIL b2b_first: got %h/%b expected 7f800000/100", res, flg);
        end
        // Now in the done cycle: a start here must be accepted and clear the flags.
        bus_if.op1       = 32'h40C00000;
        bus_if.op2       = 32'h40400000;
        bus_if.div_start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.div_start = 1'b0;
        cnt = 0;
        n_vec++;
        if ({bus_if.div_busy, bus_if.div_done, bus_if.div_overflow} !== 3'b100) begin
            n_miss++;
            $display("FAIL b2b_accept: busy/done/ovf got %b expected 100",
                     {bus_if.div_busy, bus_if.div_done, bus_if.div_overflow});
        end
        n_vec++;
        if (bus_if.div_result !== 32'h7F800000) begin
            n_miss++;
            $display("FAIL b2b_result_held: got %h expected %h",
                     bus_if.div_result, 32'h7F800000);
        end
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!bus_if.div_done && cnt < 40);
        n_vec++;
        if (cnt != 27 || bus_if.div_result !== 32'h40000000) begin
            n_miss++;
            $display("FAIL b2b_second: got %h after %0d expected 40000000 after 27",
                     bus_if.div_result, cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int saw_done;
        bus_if.op1       = 32'h3F800000;
        bus_if.op2       = 32'h40400000;
        bus_if.div_start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.div_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #2;
        n_vec++;
        if ({bus_if.div_result, bus_if.div_done, bus_if.div_busy} !== 34'h0) begin
            n_miss++;
            $display("FAIL abort_outputs: result %h done %b busy %b expected all 0",
                     bus_if.div_result, bus_if.div_done, bus_if.div_busy);
        end
        @(posedge clk);
        #1;
        n_rst    = 1'b1;
        saw_done = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (bus_if.div_done === 1'b1 || bus_if.div_busy === 1'b1) saw_done++;
        end
        n_vec++;
        if (saw_done != 0) begin
            n_miss++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", saw_done);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_vectors();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fp_divide.md
# fp_divide

Sequential IEEE-754 single-precision divider: computes `op1 / op2` with a radix-2 restoring mantissa divider, one quotient bit per clock, under a start/done handshake. It is the inverse-operation companion to the team's single-cycle FP multiplier and sits beside it in the FP arithmetic unit. The unit shares the multiplier's operand and result formats and its flag conventions. Normal numbers and zeros are supported; denormal inputs are flushed to zero.

## Interface
- No parameters. Format constants come from `fp_pkg`.
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `div_start`  in  1  request; sampled only in IDLE.
- `op1`  in  32  dividend, IEEE-754 single.
- `op2`  in  32  divisor, IEEE-754 single.
- `div_result`  out  32  quotient; held until the next completion.
- `div_done`  out  1  one-cycle pulse; `div_result` and the flags are valid in the same cycle.
- `div_busy`  out  1  high whenever state ≠ IDLE.
- `div_overflow`  out  1  result exponent ≥ 255; `div_result` is ±infinity.
- `div_underflow`  out  1  result exponent ≤ 0; `div_result` is ±zero.
- `div_by_zero`  out  1  `op2` is zero or denormal and `op1` is nonzero.

## Operation
- States are IDLE, DIVIDE, NORM.
- **IDLE, `div_start`=1:** latch sign = `op1[31]^op2[31]`. Compute the 10-bit signed exponent `e = e1 - e2 + 127`. Latch mantissas `M1={1,f1}` and `M2={1,f2}`, clear the 5-bit counter, go to DIVIDE.
- **Special cases are checked in IDLE** and skip DIVIDE:
  - Either exponent is 255: result `0x7FC00000`, no flags.
  - `op2` is zero (exp=0): result `{sign,8'hFF,23'h0}`, `div_by_zero`=1.
  - `op1` is zero: result `{sign,31'h0}`.
  - `op1` and `op2` both zero: NaN `0x7FC00000`.
- **DIVIDE:** a restoring step runs each cycle. Remainder R is 26 bits, initialised to M1. Each step:
  - If R ≥ M2: q bit = 1, R = R − M2.
  - Else: q bit = 0.
  - Then R = R<<1.
  - q is filled MSB first.
  - After 26 steps, q[25:0] is complete, with q[25] carrying weight 2^0. Go to NORM.
- **NORM:**
  - If q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(R≠0).
  - Else: mant=q[23:1], guard=q[0], sticky=(R≠0), and e = e − 1.
  - Optional rounding per Configuration. A mantissa carry-out increments e.
  - e ≥ 255: `{sign,8'hFF,0}`, `div_overflow`=1.
  - e ≤ 0: `{sign,31'h0}`, `div_underflow`=1.
  - Otherwise: `{sign,e[7:0],mant}`.
  - Register result and flags, pulse `div_done`, go to IDLE.
- Flags are updated on every completion and cleared on the next accepted start.
- `div_start` is ignored while busy. Operands are not re-sampled after acceptance.

## Timing
- `div_start` sampled high at edge k:
  - Normal operands: `div_done` is high from edge k+27 to k+28 (26 DIVIDE cycles plus NORM).
  - Special cases: `div_done` is high from edge k+1.
- During the `div_done` cycle the state is already IDLE, so a `div_start` there is accepted. Back-to-back operations are allowed.
- Reset values: `div_result`=0, `div_done`=0, `div_busy`=0, all flags=0, state IDLE.
- Reset asserted mid-operation aborts immediately. No `div_done` follows.

## Configuration
- `FP_DIV_RNE_EN` defined: round-to-nearest-even. Increment mant if `guard & (sticky | mant[0])`. A carry to 2.0 gives mant=0 and e+1, and can produce overflow.
- Undefined: truncate (round toward zero); guard and sticky are ignored. Latency is identical in both builds.

## Structure
- **`fp_pkg`:** `fp32_t` packed struct (sign, exp[7:0], frac[22:0]), `FP_BIAS=8'd127`, `FP_EXP_MAX=8'hFF`, `FP_QNAN=32'h7FC00000`, and a state enum. The multiplier imports the same package.
- **`fp_div_mant` sub-module:** iterative restoring mantissa divider. Inputs: load, M1, M2. Contains the counter, R and q. Outputs: q[25:0], rem_nz, mant_done.
- **`fp_divide`:** top level; handles unpack, special cases, normalise, round and the output registers.

## Test plan
- `0x40C00000 / 0x40400000` (6.0/3.0) → `0x40000000`, `div_done` exactly 27 cycles after start, no flags.
- `0x3FF00000 / 0x3FC00000` (1.875/1.5) → `0x3FA00000`; `0xC0C00000 / 0x40400000` → `0xC0000000`.
- `0x3F800000 / 0x40400000` (1/3) → `0x3EAAAAAB` with `FP_DIV_RNE_EN`, `0x3EAAAAAA` without.
- `0x3F800000 / 0x00000000` → `0x7F800000`, `div_by_zero`=1, done 1 cycle after start; `0 / 0` → `0x7FC00000`.
- `0x7F000000 / 0x3E800000` → `0x7F800000`, `div_overflow`=1; `0x00800000 / 0x7F000000` → `0x00000000`, `div_underflow`=1.
- Reset pulse at cycle 10 of an operation → all outputs 0, no done. Second start during busy is ignored. Start in the done cycle is accepted.
